// File: rtl/aer_tx_arbiter_if.sv
// Bus bundle for the AER transmit arbiter.
//   req       : per-requester event request (4-phase, synchronous to clk)
//   grant     : per-requester completion acknowledge (one-hot or zero)
//   zero_out  : link rail for a "0" symbol (return-to-zero)
//   one_out   : link rail for a "1" symbol (return-to-zero)
//   link_ack  : asynchronous acknowledge from the remote receiver
//   busy      : arbiter is not idle
//   frame_cnt : count of completed frames (wraps)
// Modports: master = arbiter side, slave = requesters/link side.
interface aer_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned FRAME_CNT_W = 8;

    logic [NUM_REQ-1:0]     req;
    logic [NUM_REQ-1:0]     grant;
    logic                   zero_out;
    logic                   one_out;
    logic                   link_ack;
    logic                   busy;
    logic [FRAME_CNT_W-1:0] frame_cnt;

    modport master (
        input  req,
        input  link_ack,
        output grant,
        output zero_out,
        output one_out,
        output busy,
        output frame_cnt
    );

    modport slave (
        output req,
        output link_ack,
        input  grant,
        input  zero_out,
        input  one_out,
        input  busy,
        input  frame_cnt
    );
endinterface

// File: rtl/aer_tx_arbiter.sv
// Round-robin arbiter that serialises the winning requester's address onto a
// dual-rail return-to-zero link (one rail per symbol value) and completes a
// 4-phase handshake with the requester once the whole frame is acknowledged.
// Frame: start "1", address MSB first, optional even-parity bit, stop "0".
// Optional feature macro: AER_PARITY_EN (adds the parity symbol).
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous, active-low
//   bus   : aer_tx_arbiter_if.master (req, grant, rails, link_ack, busy, frame_cnt)
module aer_tx_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    aer_tx_arbiter_if.master   bus
);

`ifdef AER_PARITY_EN
    localparam int unsigned FRAME_LEN = ADDR_W + 3;
`else
    localparam int unsigned FRAME_LEN = ADDR_W + 2;
`endif
    localparam int unsigned CNT_W = $clog2(FRAME_LEN);
    localparam int unsigned FCNT_W = 8;

    typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO, DONE} state_t;

    state_t                state_q, state_d;
    logic                  ack_meta_q, ack_s_q;
    logic [ADDR_W-1:0]     ptr_q, ptr_d;
    logic [ADDR_W-1:0]     w_q, w_d;
    logic [FRAME_LEN-1:0]  shreg_q, shreg_d;
    logic [CNT_W-1:0]      left_q, left_d;
    logic                  zero_q, zero_d;
    logic                  one_q, one_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [FCNT_W-1:0]     cnt_q, cnt_d;
    logic                  busy_q, busy_d;

    logic                  arb_found;
    logic [ADDR_W-1:0]     arb_idx;
    logic [ADDR_W-1:0]     cand;
    logic [FRAME_LEN-1:0]  frame_word;

    // Two-flop synchronizer for the remote acknowledge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
        end else begin
            ack_meta_q <= bus.link_ack;
            ack_s_q    <= ack_meta_q;
        end
    end

    // Round-robin search: first set request at or above ptr, wrapping
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = ADDR_W'((32'(ptr_q) + i) % NUM_REQ);
            if (!arb_found && bus.req[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // Frame image for the current winner, first symbol in the MSB
    always_comb begin
`ifdef AER_PARITY_EN
        frame_word = {1'b1, arb_idx, ^arb_idx, 1'b0};
`else
        frame_word = {1'b1, arb_idx, 1'b0};
`endif
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            w_q     <= '0;
            shreg_q <= '0;
            left_q  <= '0;
            zero_q  <= 1'b0;
            one_q   <= 1'b0;
            grant_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            w_q     <= w_d;
            shreg_q <= shreg_d;
            left_q  <= left_d;
            zero_q  <= zero_d;
            one_q   <= one_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        w_d     = w_q;
        shreg_d = shreg_q;
        left_d  = left_q;
        zero_d  = zero_q;
        one_d   = one_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                // A stale acknowledge blocks the start of a new frame
                if (arb_found && !ack_s_q) begin
                    w_d     = arb_idx;
                    one_d   = frame_word[FRAME_LEN-1];
                    zero_d  = ~frame_word[FRAME_LEN-1];
                    shreg_d = frame_word << 1;
                    left_d  = CNT_W'(FRAME_LEN - 1);
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (ack_s_q) begin
                    zero_d  = 1'b0;
                    one_d   = 1'b0;
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!ack_s_q) begin
                    if (left_q != '0) begin
                        one_d   = shreg_q[FRAME_LEN-1];
                        zero_d  = ~shreg_q[FRAME_LEN-1];
                        shreg_d = shreg_q << 1;
                        left_d  = left_q - CNT_W'(1);
                        state_d = WAIT_HI;
                    end else begin
                        grant_d = NUM_REQ'(1) << w_q;
                        cnt_d   = cnt_q + FCNT_W'(1);
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (!bus.req[w_q]) begin
                    grant_d = '0;
                    ptr_d   = ADDR_W'((32'(w_q) + 1) % NUM_REQ);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.grant     = grant_q;
    assign bus.zero_out  = zero_q;
    assign bus.one_out   = one_q;
    assign bus.busy      = busy_q;
    assign bus.frame_cnt = cnt_q;

endmodule

// File: tb/tb_aer_tx_arbiter.sv
// Self-checking bench for aer_tx_arbiter: a table of request patterns with
// expected winners, plus hand-written sequences for round-robin rotation,
// stale acknowledge, reset mid-frame and frame counter wrap. Expected symbols
// and grants are queued when a request is driven and compared when the DUT
// puts them on the link.
module tb_aer_tx_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int LIMIT = 400;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic resp_en = 1'b1;
    logic ack_force = 1'b0;
    logic [1:0] dly;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [3:0] grant;
        logic [7:0] cnt;
    } gnt_t;

    typedef struct {
        logic [3:0] req;
        int         winner;
    } vec_t;

    logic sym_q[$];
    gnt_t gnt_q[$];
    logic [7:0] exp_cnt = 8'd0;
    vec_t vtab[8];

    aer_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    aer_tx_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Ideal receiver: acknowledge follows the rails two cycles later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dly <= 2'b00;
        else        dly <= {dly[0], bus.one_out | bus.zero_out};
    end
    assign bus.link_ack = resp_en ? dly[1] : ack_force;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input int w);
        logic [1:0] a;
        gnt_t g;
        a = 2'(w);
        sym_q.push_back(1'b1);
        sym_q.push_back(a[1]);
        sym_q.push_back(a[0]);
`ifdef AER_PARITY_EN
        sym_q.push_back(a[1] ^ a[0]);
`endif
        sym_q.push_back(1'b0);
        exp_cnt = exp_cnt + 8'd1;
        g.grant = 4'(1) << w;
        g.cnt   = exp_cnt;
        gnt_q.push_back(g);
    endtask

    task automatic wait_grant(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.grant == '0 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (bus.grant == '0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: grant timeout, got 0, expected nonzero", name);
        end
    endtask

    task automatic wait_busy(input string name, input logic val);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy !== val && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy !== val) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: busy timeout, got %b, expected %b", name, bus.busy, val);
        end
    endtask

    // Link and grant monitor
    logic prev_one, prev_zero;
    logic [3:0] prev_grant;
    int gwidth;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_one   = 1'b0;
            prev_zero  = 1'b0;
            prev_grant = '0;
            gwidth     = 0;
        end else begin
            if (bus.one_out && bus.zero_out) begin
                miscompares++;
                $display("FAIL rails_both_high: got one=1 zero=1, expected at most one");
            end
            if (!$onehot0(bus.grant) || (bus.grant != '0 && !bus.busy)) begin
                miscompares++;
                $display("FAIL grant_shape: got grant=%b busy=%b, expected one-hot while busy", bus.grant, bus.busy);
            end
            if ((bus.one_out && !prev_one) || (bus.zero_out && !prev_zero)) begin
                if (sym_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_symbol: got %b, expected none", bus.one_out);
                end else begin
                    check("symbol", 32'(bus.one_out), 32'(sym_q.pop_front()));
                end
            end
            if (bus.grant != '0 && prev_grant == '0) begin
                if (gnt_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_grant: got %b, expected none", bus.grant);
                end else begin
                    gnt_t e;
                    e = gnt_q.pop_front();
                    check("grant", 32'(bus.grant), 32'(e.grant));
                    check("frame_cnt", 32'(bus.frame_cnt), 32'(e.cnt));
                end
                gwidth = 1;
            end else if (bus.grant != '0) begin
                gwidth++;
            end else if (prev_grant != '0) begin
                check("grant_width", 32'(gwidth), 32'd1);
            end
            prev_one   = bus.one_out;
            prev_zero  = bus.zero_out;
            prev_grant = bus.grant;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [3:0] r;

        // Table, starting from ptr=1 (after the rotation sequence)
        vtab[0] = '{4'b0100, 2};
        vtab[1] = '{4'b0011, 0};
        vtab[2] = '{4'b1111, 1};
        vtab[3] = '{4'b1001, 3};
        vtab[4] = '{4'b1010, 1};
        vtab[5] = '{4'b0001, 0};
        vtab[6] = '{4'b0110, 1};
        vtab[7] = '{4'b0100, 2};

        bus.req = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_one_out",   32'(bus.one_out),   32'd0);
        check("rst_zero_out",  32'(bus.zero_out),  32'd0);
        check("rst_grant",     32'(bus.grant),     32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Rotation: all requesting, each drops on grant and re-raises
        r = 4'b1111;
        bus.req = r;
        for (int i = 0; i < 5; i++) begin
            push_frame(i % 4);
            wait_grant("rr");
            if (i == 4) r = '0;
            else        r[i % 4] = 1'b0;
            bus.req = r;
            wait_busy("rr_idle", 1'b0);
            if (i < 4) r[i % 4] = 1'b1;
            bus.req = r;
        end
        repeat (2) @(negedge clk);

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            push_frame(vtab[i].winner);
            bus.req = vtab[i].req;
            wait_grant("table");
            bus.req = '0;
            wait_busy("table_idle", 1'b0);
        end

        // Stale acknowledge holds off the start
        resp_en   = 1'b0;
        ack_force = 1'b1;
        repeat (4) @(negedge clk);
        push_frame(0);
        bus.req = 4'b0001;
        repeat (10) @(negedge clk);
        check("stale_no_start", 32'({bus.one_out, bus.zero_out, bus.busy}), 32'd0);
        @(posedge clk);
        #1 ack_force = 1'b0;
        n = 0;
        while (n < 10) begin
            @(posedge clk);
            n++;
            #1;
            if (bus.one_out || bus.zero_out) break;
        end
        check("stale_latency", 32'(n), 32'd3);
        resp_en = 1'b1;
        wait_grant("stale");
        bus.req = '0;
        wait_busy("stale_idle", 1'b0);

        // Reset while waiting for the first acknowledge
        resp_en = 1'b0;
        push_frame(1);
        bus.req = 4'b0010;
        wait_busy("mid_start", 1'b1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_rails", 32'({bus.one_out, bus.zero_out}), 32'd0);
        check("midrst_busy",  32'(bus.busy),      32'd0);
        check("midrst_grant", 32'(bus.grant),     32'd0);
        check("midrst_cnt",   32'(bus.frame_cnt), 32'd0);
        sym_q.delete();
        gnt_q.delete();
        exp_cnt = 8'd0;
        bus.req = '0;
        resp_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_frame(0);
        bus.req = 4'b1001;
        wait_grant("post_rst");
        bus.req = '0;
        wait_busy("post_rst_idle", 1'b0);

        // 255 more frames with the request withdrawn mid-frame
        for (int k = 0; k < 255; k++) begin
            push_frame(k % 4);
            bus.req = 4'(1) << (k % 4);
            wait_busy("wrap_start", 1'b1);
            bus.req = '0;
            wait_grant("wrap");
            wait_busy("wrap_idle", 1'b0);
        end
        check("frame_cnt_wrap", 32'(bus.frame_cnt), 32'd0);
        repeat (4) @(negedge clk);
        check("symbols_left", 32'(sym_q.size()), 32'd0);
        check("grants_left",  32'(gnt_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aer_tx_arbiter.md
AER_TX_ARBITER -- requirements
Module: aer_tx_arbiter

Interface
REQ-001 NUM_REQ, 4, number of event requesters; ADDR_W, 2, address width, equal to log2(NUM_REQ).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 REQ  input  NUM_REQ  per-requester event request, 4-phase handshake, synchronous to clk.
REQ-005 GRANT  output  NUM_REQ  per-requester completion acknowledge, one-hot or zero.
REQ-006 ZERO_OUT  output  1  link rail for a "0" symbol, return-to-zero.
REQ-007 ONE_OUT  output  1  link rail for a "1" symbol, return-to-zero.
REQ-008 LINK_ACK  input  1  asynchronous acknowledge from the remote Reciever.
REQ-009 BUSY  output  1  high in every state except IDLE.
REQ-010 FRAME_CNT  output  8  count of completed frames.

Function
REQ-011 LINK_ACK passes through a 2-flop synchronizer; only the synchronized value (ack_s) is used.
REQ-012 States: IDLE, WAIT_HI, WAIT_LO, DONE.
REQ-013 IDLE -> WAIT_HI on a clk edge when REQ!=0 and ack_s==0.
- On that edge: latch winner w, load the frame shift register, and assert the first symbol rail.
- The rail is therefore high 1 cycle after REQ is sampled.
REQ-014 Arbitration is round-robin:
- Search starts at index ptr and ascends modulo NUM_REQ; the first REQ bit found wins.
- ptr = (w+1) mod NUM_REQ on exit from DONE.
REQ-015 Frame symbol order:
- start symbol "1";
- ADDR_W address bits of w, MSB first;
- optional parity symbol (REQ-031);
- stop symbol "0".
REQ-016 Each symbol drives ONE_OUT for "1" or ZERO_OUT for "0"; exactly one rail is high per symbol.
REQ-017 WAIT_HI: when ack_s==1, deassert the rail and go to WAIT_LO.
REQ-018 WAIT_LO: when ack_s==0:
- if symbols remain, assert the next rail and go to WAIT_HI;
- otherwise set GRANT[w]=1, increment FRAME_CNT, and go to DONE.
REQ-019 DONE: when REQ[w]==0, clear GRANT, update ptr, and go to IDLE. If REQ[w] is already low on entry, GRANT is high for exactly 1 cycle.
REQ-020 ZERO_OUT and ONE_OUT are never high in the same cycle, in any state.
REQ-021 A REQ withdrawn mid-frame does not abort the frame; the frame completes.
REQ-022 REQ changes during a frame do not alter the latched w or the frame contents.
REQ-023 If ack_s==1 in IDLE (stale acknowledge), no frame starts until ack_s==0.
REQ-024 FRAME_CNT wraps from 255 to 0.
REQ-025 GRANT has at most one bit set, and only in DONE.
REQ-026 No timeout: the block waits indefinitely for LINK_ACK.

Reset
REQ-027 While reset==0, the following are held asynchronously: state=IDLE, ZERO_OUT=0, ONE_OUT=0, GRANT=0, BUSY=0, FRAME_CNT=0, ptr=0, synchronizer flops=0.
REQ-028 Reset asserted mid-frame drops the rails immediately; the partial frame is neither counted nor granted.
REQ-029 After reset release, the first arbitration starts at index 0.

Configuration
REQ-030 Macro AER_PARITY_EN selects whether a parity symbol is sent.
REQ-031 With AER_PARITY_EN defined:
- an even-parity symbol (XOR of the address bits) is sent after the address;
- frame length is ADDR_W+3 symbols.
REQ-032 Without AER_PARITY_EN:
- no parity symbol is sent;
- frame length is ADDR_W+2 symbols.

Verification
REQ-033 Single request, parity enabled: REQ=4'b0100 with an ideal ack responder (2-cycle delay) -> rail sequence ONE,ONE,ZERO,ONE,ZERO; then GRANT=4'b0100, FRAME_CNT=1.
REQ-034 Round-robin: REQ=4'b1111 held, each requester dropping REQ when granted and re-raising afterwards -> grants in order 0,1,2,3,0; ptr wraps correctly.
REQ-035 Parity disabled: REQ=4'b0011, grant to requester 0 -> rail sequence ONE,ZERO,ZERO,ZERO (4 symbols).
REQ-036 Stale ack: LINK_ACK held high, then REQ=4'b0001 -> no rail rises until LINK_ACK falls; the rail rises 3 cycles after the fall (2 sync + 1).
REQ-037 Reset mid-frame: reset=0 while in WAIT_HI -> rails=0, BUSY=0, GRANT=0, FRAME_CNT unchanged at 0; next frame after release starts at requester 0.
REQ-038 Wrap and withdrawal: 256 frames with REQ dropped mid-frame -> each GRANT is a 1-cycle pulse; FRAME_CNT reads 0 after frame 256; rails are never both high.
